// File: rtl/mdu_sequencer.sv
// Iterative RV32/64 M-extension multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, with single-cycle handling of divide-by-zero and signed overflow.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          op_reg, op_next;
    logic                neg_reg, neg_next;
    logic [XLEN-1:0]     opnd_reg, opnd_next;
    logic [2*XLEN:0]     acc_reg, acc_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [XLEN-1:0]     result_reg, result_next;

    // Operand signedness and magnitudes, evaluated on the live inputs at acceptance
    logic            a_signed, b_signed;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_result;

    always_comb begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        case (funct3)
            3'b010:                 b_signed = 1'b0;
            3'b011, 3'b101, 3'b111: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
            default: ;
        endcase
    end

    assign sign_a   = a_signed & operand_a[XLEN-1];
    assign sign_b   = b_signed & operand_b[XLEN-1];
    assign mag_a    = sign_a ? -operand_a : operand_a;
    assign mag_b    = sign_b ? -operand_b : operand_b;
    assign div_zero = funct3[2] && (operand_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (operand_a == MIN_NEG) && (operand_b == '1);

    always_comb begin
        if (div_zero)
            special_result = funct3[1] ? operand_a : '1;
        else
            special_result = funct3[1] ? '0 : operand_a;
    end

    // Multiply step: accumulate the multiplicand into the upper half, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN:0]   mul_acc;

    assign mul_sum  = acc_reg[2*XLEN:XLEN] + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign prod_raw = {mul_sum, acc_reg[XLEN-1:1]};
    assign mul_acc  = {1'b0, prod_raw};

    // Divide step: shift remainder/quotient left, trial-subtract, restore on borrow
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] q_shift;
    logic [XLEN:0]   rem_next;
    logic [2*XLEN:0] div_acc;

    assign rem_shift = acc_reg[2*XLEN-1:XLEN-1];
    assign diff      = {1'b0, rem_shift} - {2'b00, opnd_reg};
    assign q_shift   = {acc_reg[XLEN-2:0], ~diff[XLEN+1]};
    assign rem_next  = diff[XLEN+1] ? rem_shift : diff[XLEN:0];
    assign div_acc   = {rem_next, q_shift};

    // Result of the final iteration, with sign correction applied
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   rem_mag, q_final, r_final;
    logic [XLEN-1:0]   mul_result, div_result, calc_result;

    assign prod_signed = neg_reg ? -prod_raw : prod_raw;
    assign rem_mag     = rem_next[XLEN-1:0];
    assign q_final     = neg_reg ? -q_shift : q_shift;
    assign r_final     = neg_reg ? -rem_mag : rem_mag;
    assign mul_result  = (op_reg[1:0] == 2'b00) ? prod_signed[XLEN-1:0]
                                                : prod_signed[2*XLEN-1:XLEN];
    assign div_result  = op_reg[1] ? r_final : q_final;
    assign calc_result = op_reg[2] ? div_result : mul_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            neg_reg    <= neg_next;
            opnd_reg   <= opnd_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        neg_next    = neg_reg;
        opnd_next   = opnd_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next = funct3;
                    if (div_zero || div_ovf) begin
                        result_next = special_result;
                        state_next  = DONE;
                    end else begin
                        // Divide keeps the dividend in the low half; multiply keeps the multiplier there
                        acc_next   = {{(XLEN+1){1'b0}}, (funct3[2] ? mag_a : mag_b)};
                        opnd_next  = funct3[2] ? mag_b : mag_a;
                        neg_next   = (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
                        cnt_next   = '0;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                acc_next = op_reg[2] ? div_acc : mul_acc;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    result_next = calc_result;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A flush abandons whatever was decided above and leaves the result untouched
        if (kill) begin
            state_next  = IDLE;
            result_next = result_reg;
        end
    end

    assign busy   = (state_reg == CALC);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomised and directed bench for mdu_sequencer (XLEN=32) against an
// arithmetic reference model built on 64-bit integer math.
module tb_mdu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_exp = '0;

    mdu_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          p;
        longint unsigned pu;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pu = ua / ub; return pu[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = ua % ub; return pu[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge after acceptance
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3    = f;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        funct3    = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic finish_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int          k = 1;
        int          nbusy = 0;
        bit          seen = 0;
        bit          sp = is_special(f, a, b);
        logic [31:0] exp = model(f, a, b);
        while (!seen && k < 100) begin
            if (done) seen = 1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
                k++;
            end
        end
        check("latency", 64'(k), sp ? 64'd1 : 64'd33);
        check("busy_cycles", 64'(nbusy), sp ? 64'd0 : 64'd32);
        check("result", 64'(result), 64'(exp));
        $display("op f3=%0d a=%h b=%h result=%h expected=%h lat=%0d", f, a, b, result, exp, k);
        last_exp = exp;
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        issue(f, a, b);
        finish_op(f, a, b);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t dir_vecs[12] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
        '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
        '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
        '{3'd1, 32'h8000_0000,  32'h8000_0000},
        '{3'd4, 32'hFFFF_FFF9,  32'd2},
        '{3'd6, 32'hFFFF_FFF9,  32'd2},
        '{3'd5, 32'd100,        32'd7},
        '{3'd4, 32'd5,          32'd0},
        '{3'd7, 32'd5,          32'd0},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF}
    };

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        kill      = 1'b0;
        funct3    = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (dir_vecs[i]) run_op(dir_vecs[i].f, dir_vecs[i].a, dir_vecs[i].b);

        // kill together with start in IDLE: nothing accepted
        funct3 = 3'd0; operand_a = 32'd3; operand_b = 32'd4;
        start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("killstart_busy", 64'(busy), 64'd0);
        check("killstart_done", 64'(done), 64'd0);
        @(negedge clk);
        check("killstart_done2", 64'(done), 64'd0);
        check("killstart_result", 64'(result), 64'(last_exp));

        // kill mid-divide, then immediate restart
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_done", 64'(done), 64'd0);
        check("kill_result", 64'(result), 64'(last_exp));
        $display("abort kill result=%h", result);
        run_op(3'd5, 32'd100, 32'd7);

        // reset mid-divide clears the result, then immediate restart
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        $display("abort rst result=%h", result);
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);

        // start held high across several passes
        begin
            int pulses = 0, first = -1, gap = -1, dbl = 0;
            bit prev_done = 0;
            logic [31:0] exp = model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
            funct3 = 3'd3; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0;
            start = 1'b1;
            for (int t = 1; t <= 110; t++) begin
                @(negedge clk);
                if (done) begin
                    pulses++;
                    if (prev_done) dbl++;
                    if (first < 0) first = t;
                    else if (gap < 0) gap = t - first;
                    check("hold_result", 64'(result), 64'(exp));
                end
                prev_done = done;
            end
            start = 1'b0;
            check("hold_pulses", 64'(pulses), 64'd3);
            check("hold_double", 64'(dbl), 64'd0);
            check("hold_first", 64'(first), 64'd33);
            check("hold_gap", 64'(gap), 64'd34);
            $display("hold pulses=%0d first=%0d gap=%0d", pulses, first, gap);
            last_exp = exp;
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            int          r = $urandom_range(0, 9);
            if (r == 0) b = '0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'($urandom_range(1, 15));
            else if (r == 3) a = 32'h8000_0000;
            run_op(f, a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
